// File: rtl/rr_arb4_idx_pkg.sv
// rr_arb4_idx_pkg: shared arbiter widths and FSM state encoding
package rr_arb4_idx_pkg;
  localparam int NUM_CH = 4;
  localparam int IDX_W = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_arb4_idx_pick4.sv
// rr_pick4: rotating-priority picker, first request after i_last wins
module rr_pick4
  import rr_arb4_idx_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_last,
  output logic              o_any,
  output logic [IDX_W-1:0]  o_idx
);
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    // Scan farthest-first so the nearest candidate after i_last overwrites last
    for (int k = NUM_CH; k >= 1; k--)
      if (i_req[i_last + IDX_W'(k)]) o_idx = i_last + IDX_W'(k);
  end
endmodule

// File: rtl/rr_arb4_idx.sv
// rr_arb4_idx: 4-channel round-robin arbiter with hold timeout and idle gap
module rr_arb4_idx
  import rr_arb4_idx_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic              gnt_en,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              busy,
  output logic              timeout
);
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);
  state_t r_state, w_state;
  logic [IDX_W-1:0] r_idx, w_idx, r_last, w_last, w_pick;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_to, w_to, w_any, w_lim, w_rel;
  rr_pick4 u_pick (
    .i_req (req),
    .i_last(r_last),
    .o_any (w_any),
    .o_idx (w_pick)
  );
  always_comb begin
    w_lim = r_cnt == CNT_MAX;
    w_rel = done | ~req[r_idx] | w_lim;
    w_state = r_state;
    w_idx = r_idx;
    w_last = r_last;
    w_cnt = r_cnt;
    w_to = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_any) begin
        w_state = ST_GRANT;
        w_idx = w_pick;
        w_last = w_pick;
        w_cnt = '0;
      end
    end else if (w_rel) begin
      // Release always passes through IDLE, guaranteeing the one-cycle gap
      w_state = ST_IDLE;
      w_to = w_lim & ~done & req[r_idx];
    end else begin
      w_cnt = r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx <= '0;
      r_last <= 2'b11;
      r_cnt <= '0;
      r_to <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx <= w_idx;
      r_last <= w_last;
      r_cnt <= w_cnt;
      r_to <= w_to;
    end
  end
  assign gnt_en = r_state == ST_GRANT;
  assign busy = r_state == ST_GRANT;
  assign gnt_idx = r_idx;
  assign timeout = r_to;
endmodule
